program_feeder: RTL and testbench
=================================

// Module: program_feeder
// PURPOSE
//  Upstream instruction source for tt_um_8_bit_cpu. Holds a loadable program (opcode + immediate per word),
//  tracks the CPU's 5-phase sequence, and drives the CPU's ui_in byte: opcode in FETCH, immediate in DECODE.
//  Also holds the CPU in reset while a program is loaded and flags loss of phase lock.
// PARAMETERS
//  ADDR_W   6      word address width; must match CPU pc bits exported on uio_out[5:0]
//  DEPTH    64     program words (<= 2**ADDR_W)
//  NOP_BYTE 8'h00  byte driven for addresses >= prog_len and outside FETCH/DECODE
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst_n        in   1       asynchronous active-low reset
//  load_en      in   1       1 = LOAD mode (program write), 0 = RUN mode
//  load_valid   in   1       load byte strobe
//  load_data    in   8       load byte: even byte = opcode, odd byte = immediate
//  load_ready   out  1       feeder accepts load_data this cycle
//  prog_len     out  ADDR_W+1 number of complete words loaded
//  cpu_pc       in   ADDR_W  CPU program counter (uio_out[5:0])
//  cpu_send_ins in   1       CPU OUTPUT-phase flag (uio_out[7])
//  cpu_invalid  in   1       CPU invalid-opcode flag (uio_out[6])
//  cpu_ui       out  8       byte to CPU ui_in
//  cpu_rst_n    out  1       CPU reset = rst_n & ~loading (registered deassert)
//  sync_err     out  1       sticky: feeder phase disagrees with cpu_send_ins
// BEHAVIOUR
//  Reset: mode LOAD-idle, wp=0, half=0, prog_len=0, phase=FETCH, cpu_ui=NOP_BYTE, load_ready=0,
//   cpu_rst_n=0, sync_err=0. Memory contents not reset.
//  Mode FSM: IDLE -> LOAD when load_en=1; LOAD -> RUN when load_en=0; RUN -> LOAD when load_en=1
//   (restarts at wp=0, half=0, prog_len=0). IDLE -> RUN when load_en=0 after reset.
//  LOAD: load_ready = (wp < DEPTH). Accept on load_valid&load_ready: half=0 -> opcode[wp]=data, half=1;
//   half=1 -> imm[wp]=data, half=0, wp++, prog_len=wp+1. Bytes while not ready are dropped.
//   Leaving LOAD with half=1 discards the orphan opcode (prog_len unchanged).
//  cpu_rst_n: 0 in IDLE/LOAD; goes 1 on the first posedge in RUN; asserts async with rst_n.
//  Phase tracker (RUN only, starts in FETCH the cycle cpu_rst_n rises):
//   FETCH->DECODE; DECODE->FETCH if cpu_invalid else EXECUTE; EXECUTE->WRITEBACK->OUTPUT->FETCH.
//  cpu_ui (combinational from phase, cpu_pc, memory): FETCH -> opcode[cpu_pc]; DECODE -> imm[cpu_pc];
//   other phases, or cpu_pc >= prog_len -> NOP_BYTE. LOAD/IDLE -> NOP_BYTE.
//  sync_err set when (phase==OUTPUT) != cpu_send_ins while in RUN; cleared only by rst_n or entering LOAD.
//  Simultaneous: load_en rise while RUN in any phase -> LOAD next cycle, cpu_rst_n=0 same edge, phase=FETCH.
//  pc wrap: cpu_pc wraps 63->0 in CPU; feeder follows pc, no own counter.
//  Full: wp==DEPTH -> load_ready=0, prog_len=DEPTH.
// STRUCTURE
//  Shared package cpu_pkg: phase encodings FETCH..OUTPUT (3'b000..3'b100, identical to CPU), NOP opcode,
//   PC width. Sub-module program_mem (DEPTH x 16 flop array, one write port, one comb read port).
//  Top holds mode FSM, load pointer, phase tracker, sync checker.
// TESTING
//  Load 4 bytes {8'h11,8'h05,8'h22,8'h07}, load_en=0 -> prog_len=2, cpu_rst_n rises next edge,
//   cpu_ui = 8'h11 in FETCH, 8'h05 in DECODE with cpu_pc=0.
//  Load 3 bytes then drop load_en -> prog_len=1; word 1 reads NOP_BYTE.
//  Stream 130 bytes with load_valid held -> load_ready falls after byte 128, prog_len=64.
//  RUN, cpu_invalid=1 in DECODE -> next phase FETCH, cpu_ui=opcode[cpu_pc].
//  RUN, hold cpu_send_ins=0 through OUTPUT -> sync_err=1, stays 1; raise load_en -> clears.
//  Assert rst_n=0 mid-EXECUTE -> cpu_rst_n=0, cpu_ui=NOP_BYTE immediately, prog_len=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared between tt_um_8_bit_cpu and its program feeder.
//   - phase_e : the CPU's 5-phase instruction sequence. The encodings must
//               match the CPU's own phase register bit for bit.
//   - mode_e  : feeder operating mode (idle after reset, loading, running).
//   - PC_W    : width of the CPU program counter exported on uio_out[5:0].
//   - NOP_OPCODE : byte the CPU decodes as "do nothing".
//   - next_phase(): phase sequencing, including the early return to FETCH
//                   when the CPU flags an invalid opcode in DECODE.
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int         PC_W       = 6;
  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    PH_FETCH     = 3'b000,
    PH_DECODE    = 3'b001,
    PH_EXECUTE   = 3'b010,
    PH_WRITEBACK = 3'b011,
    PH_OUTPUT    = 3'b100
  } phase_e;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_RUN  = 2'b10
  } mode_e;

  // An invalid opcode aborts the instruction after DECODE; the CPU goes
  // straight back to FETCH without executing or emitting output.
  function automatic phase_e next_phase(input phase_e cur, input logic invalid);
    phase_e nxt;
    case (cur)
      PH_FETCH:     nxt = PH_DECODE;
      PH_DECODE:    nxt = invalid ? PH_FETCH : PH_EXECUTE;
      PH_EXECUTE:   nxt = PH_WRITEBACK;
      PH_WRITEBACK: nxt = PH_OUTPUT;
      PH_OUTPUT:    nxt = PH_FETCH;
      default:      nxt = PH_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/program_mem.sv
// ----------------------------------------------------------------------------
// program_mem
//   Program storage: DEPTH words of 16 bits, opcode in [15:8], immediate in
//   [7:0]. One synchronous byte-lane write port, one combinational read port
//   returning both bytes of the addressed word.
// Ports
//   clk        in   1        write clock
//   we         in   1        write enable
//   waddr      in   ADDR_W   write word address
//   wsel_imm   in   1        0 = write opcode byte, 1 = write immediate byte
//   wdata      in   8        byte to write
//   raddr      in   ADDR_W   read word address
//   rdata_op   out  8        opcode byte of word raddr
//   rdata_imm  out  8        immediate byte of word raddr
// ----------------------------------------------------------------------------
module program_mem #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wsel_imm,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata_op,
  output logic [7:0]        rdata_imm
);

  logic [15:0] mem [DEPTH];

  // NOTE: the array has no reset; a word is only ever read after it has been
  // written because reads are gated by prog_len in the feeder, so clearing
  // DEPTH flops on reset would buy nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wsel_imm) mem[waddr][7:0]  <= wdata;
      else          mem[waddr][15:8] <= wdata;
    end
  end

  assign rdata_op  = mem[raddr][15:8];
  assign rdata_imm = mem[raddr][7:0];

endmodule

// File: rtl/program_feeder.sv
// ----------------------------------------------------------------------------
// program_feeder
//   Instruction source for tt_um_8_bit_cpu. A program is streamed in byte by
//   byte (opcode, immediate, opcode, immediate ...) while the CPU is held in
//   reset. In RUN the feeder tracks the CPU's 5-phase sequence and presents
//   the opcode of word cpu_pc during FETCH and its immediate during DECODE.
//   A sticky flag reports when the tracked phase disagrees with the CPU's
//   OUTPUT-phase flag.
// Ports
//   clk          in   1         system clock, all state on posedge
//   rst_n        in   1         asynchronous active-low reset
//   load_en      in   1         1 = LOAD mode, 0 = RUN mode
//   load_valid   in   1         load byte strobe
//   load_data    in   8         load byte (even = opcode, odd = immediate)
//   load_ready   out  1         load byte accepted this cycle when valid
//   prog_len     out  ADDR_W+1  number of complete words loaded
//   cpu_pc       in   ADDR_W    CPU program counter (uio_out[5:0])
//   cpu_send_ins in   1         CPU OUTPUT-phase flag (uio_out[7])
//   cpu_invalid  in   1         CPU invalid-opcode flag (uio_out[6])
//   cpu_ui       out  8         byte driven onto CPU ui_in
//   cpu_rst_n    out  1         CPU reset, low while idle or loading
//   sync_err     out  1         sticky phase-lock loss flag
// ----------------------------------------------------------------------------
module program_feeder
  import cpu_pkg::*;
#(
  parameter int         ADDR_W   = PC_W,
  parameter int         DEPTH    = 64,
  parameter logic [7:0] NOP_BYTE = NOP_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_send_ins,
  input  logic              cpu_invalid,
  output logic [7:0]        cpu_ui,
  output logic              cpu_rst_n,
  output logic              sync_err
);

  // wp counts complete words, so it needs one more bit than an address to
  // represent "full" (wp == DEPTH).
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  mode_e            mode_q, mode_d;
  logic [ADDR_W:0]  wp_q;
  logic             half_q;
  phase_e           phase_q;
  logic             cpu_rst_q;
  logic             sync_err_q;

  logic             enter_load;
  logic             leave_load;
  logic             accept;
  logic             running;
  logic [7:0]       mem_op;
  logic [7:0]       mem_imm;

  // --------------------------------------------------------------------------
  // Mode FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_IDLE;
    else        mode_q <= mode_d;
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path can leave it unassigned and infer a latch.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_IDLE: mode_d = load_en ? MODE_LOAD : MODE_RUN;
      MODE_LOAD: if (!load_en) mode_d = MODE_RUN;
      MODE_RUN:  if (load_en)  mode_d = MODE_LOAD;
      default:   mode_d = MODE_IDLE;
    endcase
  end

  assign enter_load = (mode_d == MODE_LOAD) && (mode_q != MODE_LOAD);
  assign leave_load = (mode_q == MODE_LOAD) && (mode_d != MODE_LOAD);
  assign running    = (mode_q == MODE_RUN);

  // --------------------------------------------------------------------------
  // Load pointer. half_q selects which byte of word wp the next accepted
  // byte fills. A word counts toward prog_len only once its immediate lands.
  // --------------------------------------------------------------------------
  assign load_ready = (mode_q == MODE_LOAD) && (wp_q < DEPTH_W);
  assign accept     = load_valid && load_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the later assignment to half_q below wins on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      half_q <= 1'b0;
    end else if (enter_load) begin
      wp_q   <= '0;
      half_q <= 1'b0;
    end else begin
      if (accept) begin
        if (half_q) begin
          half_q <= 1'b0;
          wp_q   <= wp_q + ONE_W;
        end else begin
          half_q <= 1'b1;
        end
      end
      // An opcode without its immediate is abandoned when loading ends.
      if (leave_load) half_q <= 1'b0;
    end
  end

  assign prog_len = wp_q;

  program_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .we        (accept),
    .waddr     (wp_q[ADDR_W-1:0]),
    .wsel_imm  (half_q),
    .wdata     (load_data),
    .raddr     (cpu_pc),
    .rdata_op  (mem_op),
    .rdata_imm (mem_imm)
  );

  // --------------------------------------------------------------------------
  // CPU reset. Released on the same edge the mode enters RUN and reasserted
  // on the same edge it enters LOAD, so the CPU's first FETCH lines up with
  // the tracker's FETCH. The async clear follows rst_n immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_rst_q <= 1'b0;
    else        cpu_rst_q <= (mode_d == MODE_RUN);
  end

  assign cpu_rst_n = cpu_rst_q;

  // --------------------------------------------------------------------------
  // Phase tracker. Parked in FETCH whenever the CPU is held in reset, so it
  // starts in FETCH on the cycle cpu_rst_n rises.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_FETCH;
    end else if (mode_d != MODE_RUN) begin
      phase_q <= PH_FETCH;
    end else if (running) begin
      phase_q <= next_phase(phase_q, cpu_invalid);
    end
  end

  // --------------------------------------------------------------------------
  // Phase-lock checker: the CPU raises cpu_send_ins exactly in OUTPUT.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_q <= 1'b0;
    end else if (enter_load) begin
      sync_err_q <= 1'b0;
    end else if (running && ((phase_q == PH_OUTPUT) != cpu_send_ins)) begin
      sync_err_q <= 1'b1;
    end
  end

  assign sync_err = sync_err_q;

  // --------------------------------------------------------------------------
  // CPU input byte. Words at or beyond prog_len were never loaded in this
  // session, so they read as NOP instead of stale memory contents.
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_ui = NOP_BYTE;
    if (running && ({1'b0, cpu_pc} < wp_q)) begin
      case (phase_q)
        PH_FETCH:  cpu_ui = mem_op;
        PH_DECODE: cpu_ui = mem_imm;
        default:   cpu_ui = NOP_BYTE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_feeder.sv
// ----------------------------------------------------------------------------
// tb_program_feeder
//   Directed bench for program_feeder: load/run handshake, FETCH/DECODE byte
//   selection, partial-word discard, full-memory back-pressure, invalid-opcode
//   phase skip, sticky sync error and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_program_feeder;

  localparam int         ADDR_W = 6;
  localparam int         DEPTH  = 64;
  localparam logic [7:0] NOP    = 8'h00;

  logic              clk;
  logic              rst_n;
  logic              load_en;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic [ADDR_W:0]   prog_len;
  logic [ADDR_W-1:0] cpu_pc;
  logic              cpu_send_ins;
  logic              cpu_invalid;
  logic [7:0]        cpu_ui;
  logic              cpu_rst_n;
  logic              sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  program_feeder #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_BYTE (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .prog_len     (prog_len),
    .cpu_pc       (cpu_pc),
    .cpu_send_ins (cpu_send_ins),
    .cpu_invalid  (cpu_invalid),
    .cpu_ui       (cpu_ui),
    .cpu_rst_n    (cpu_rst_n),
    .sync_err     (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    load_en      = 1'b1;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    cpu_pc       = '0;
    cpu_send_ins = 1'b0;
    cpu_invalid  = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_cpu_rst_n",  16'(cpu_rst_n),  16'h0);
    check("rst_cpu_ui",     16'(cpu_ui),     16'(NOP));
    check("rst_load_ready", 16'(load_ready), 16'h0);
    check("rst_prog_len",   16'(prog_len),   16'h0);
    check("rst_sync_err",   16'(sync_err),   16'h0);
    #1 rst_n = 1'b1;
    tick();                                   // IDLE -> LOAD
    check("load_ready_on",  16'(load_ready), 16'h1);
    check("load_cpu_rst_n", 16'(cpu_rst_n),  16'h0);

    // ---------------- two-word program ----------------
    send_byte(8'h11);
    send_byte(8'h05);
    send_byte(8'h22);
    send_byte(8'h07);
    check("t1_prog_len", 16'(prog_len), 16'd2);
    load_en = 1'b0;
    #1;
    check("t1_rst_held", 16'(cpu_rst_n), 16'h0);
    tick();                                   // RUN, FETCH
    check("t1_rst_rise",  16'(cpu_rst_n), 16'h1);
    check("t1_fetch_pc0", 16'(cpu_ui),    16'h11);
    tick();                                   // DECODE
    check("t1_decode_pc0",  16'(cpu_ui),     16'h05);
    check("t1_ready_inrun", 16'(load_ready), 16'h0);
    tick();                                   // EXECUTE
    check("t1_execute_nop", 16'(cpu_ui), 16'(NOP));
    tick();                                   // WRITEBACK
    tick();                                   // OUTPUT
    cpu_send_ins = 1'b1;
    tick();                                   // FETCH
    cpu_send_ins = 1'b0;
    cpu_pc = 6'd1;
    #1;
    check("t1_fetch_pc1", 16'(cpu_ui), 16'h22);
    tick();                                   // DECODE
    check("t1_decode_pc1", 16'(cpu_ui), 16'h07);

    // ---------------- invalid opcode skips to FETCH ----------------
    cpu_invalid = 1'b1;
    tick();                                   // FETCH (early)
    cpu_invalid = 1'b0;
    check("inv_fetch_op", 16'(cpu_ui),   16'h22);
    check("inv_sync_ok",  16'(sync_err), 16'h0);
    cpu_pc = 6'd2;
    #1;
    check("pc_beyond_len", 16'(cpu_ui), 16'(NOP));
    cpu_pc = 6'd0;

    // ---------------- sync error: no send_ins in OUTPUT ----------------
    tick();                                   // DECODE
    tick();                                   // EXECUTE
    tick();                                   // WRITEBACK
    tick();                                   // OUTPUT
    check("sync_not_yet", 16'(sync_err), 16'h0);
    tick();                                   // FETCH
    check("sync_set", 16'(sync_err), 16'h1);
    tick();
    tick();
    check("sync_sticky", 16'(sync_err), 16'h1);
    load_en = 1'b1;
    tick();                                   // LOAD from mid-run
    check("reload_sync_clr", 16'(sync_err),   16'h0);
    check("reload_rst_low",  16'(cpu_rst_n),  16'h0);
    check("reload_len_clr",  16'(prog_len),   16'h0);
    check("reload_ui_nop",   16'(cpu_ui),     16'(NOP));
    check("reload_ready",    16'(load_ready), 16'h1);

    // ---------------- orphan opcode discarded ----------------
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    load_en = 1'b0;
    tick();                                   // RUN, FETCH
    check("t2_prog_len", 16'(prog_len), 16'd1);
    check("t2_fetch_w0", 16'(cpu_ui),   16'h33);
    cpu_pc = 6'd1;
    #1;
    check("t2_fetch_w1_nop", 16'(cpu_ui), 16'(NOP));
    cpu_pc = 6'd0;
    tick();                                   // DECODE
    check("t2_decode_w0", 16'(cpu_ui), 16'h44);
    cpu_pc = 6'd1;
    #1;
    check("t2_decode_w1_nop", 16'(cpu_ui), 16'(NOP));
    cpu_pc = 6'd0;
    tick();                                   // EXECUTE
    check("t2_exec_running", 16'(cpu_rst_n), 16'h1);

    // ---------------- async reset mid-EXECUTE ----------------
    rst_n = 1'b0;
    #1;
    check("arst_cpu_rst_n", 16'(cpu_rst_n), 16'h0);
    check("arst_cpu_ui",    16'(cpu_ui),    16'(NOP));
    check("arst_prog_len",  16'(prog_len),  16'h0);
    load_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();                                   // IDLE -> LOAD

    // ---------------- fill memory, overflow dropped ----------------
    load_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      load_data = 8'(i);
      #1;
      if (i == 127) check("full_ready_127", 16'(load_ready), 16'h1);
      if (i == 128) check("full_ready_128", 16'(load_ready), 16'h0);
      tick();
    end
    load_valid = 1'b0;
    check("full_prog_len", 16'(prog_len), 16'(DEPTH));
    load_en = 1'b0;
    cpu_pc  = 6'd63;
    tick();                                   // RUN, FETCH
    check("full_fetch_63", 16'(cpu_ui), 16'h7E);
    tick();                                   // DECODE
    check("full_decode_63", 16'(cpu_ui), 16'h7F);
    cpu_pc = 6'd0;
    #1;
    check("full_decode_0", 16'(cpu_ui), 16'h01);
    cpu_invalid = 1'b1;
    tick();                                   // FETCH (early)
    cpu_invalid = 1'b0;
    check("full_fetch_0", 16'(cpu_ui), 16'h00);
    cpu_pc = 6'd1;
    #1;
    check("full_fetch_1", 16'(cpu_ui),   16'h02);
    check("full_sync_ok", 16'(sync_err), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
